dtc_pe_feeder: RTL and testbench

//  Operand transmitter and result collector for the dot-product PE.
//  - Packs a serial stream of FP32 (a,b) pairs into N_MUL-wide vectors and drives pe_in_a/pe_in_b.
//  - Tracks the PE's fixed latency and captures each matching pe_out into a result FIFO.
//  - Uses credits so the FIFO never overflows. The PE has no backpressure and no valid signal.

---
 rtl/dtc_pkg.sv | 25 ++
 rtl/dtc_pe_feeder_if.sv | 34 +++
 rtl/dtc_sync_fifo.sv | 72 +++++++
 rtl/dtc_pe_feeder.sv | 144 ++++++++++++++
 tb/tb_dtc_pe_feeder.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dtc_pkg.sv
// Shared constants, result payload type and helpers for the dot-product PE feeder.
package dtc_pkg;

  localparam int unsigned DW_FP32        = 32;
  localparam int unsigned PE_LAT_DEFAULT = 12;

  // One result FIFO entry: PE output plus its group-closing tag.
  typedef struct packed {
    logic                 last;
    logic [DW_FP32-1:0]   data;
  } dtc_res_t;

  // +0 or -0: every bit except the sign is clear.
  function automatic logic fp32_is_zero(input logic [DW_FP32-1:0] x);
    return x[DW_FP32-2:0] == '0;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/dtc_pe_feeder_if.sv
// Operand stream, PE operand/result wires and result stream of the PE feeder.
interface dtc_pe_feeder_if
  import dtc_pkg::*;
#(
  parameter int unsigned N_MUL = 8,
  parameter int unsigned DW    = DW_FP32
) ();

  logic                  s_valid;
  logic                  s_ready;
  logic [DW-1:0]         s_a;
  logic [DW-1:0]         s_b;
  logic                  s_last;
  logic [DW*N_MUL-1:0]   pe_in_a;
  logic [DW*N_MUL-1:0]   pe_in_b;
  logic [DW-1:0]         pe_out;
  logic                  m_valid;
  logic                  m_ready;
  logic [DW-1:0]         m_data;
  logic                  m_last;
  logic                  err_ovf;

  // master: the feeder itself; slave: the surrounding environment.
  modport master (
    input  s_valid, s_a, s_b, s_last, pe_out, m_ready,
    output s_ready, pe_in_a, pe_in_b, m_valid, m_data, m_last, err_ovf
  );

  modport slave (
    output s_valid, s_a, s_b, s_last, pe_out, m_ready,
    input  s_ready, pe_in_a, pe_in_b, m_valid, m_data, m_last, err_ovf
  );

endinterface

// File: rtl/dtc_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; a push while full is dropped and flagged.
module dtc_sync_fifo
  import dtc_pkg::*;
#(
  parameter  int unsigned W     = 33,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned CW    = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          ovf_c
);

  localparam int unsigned AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign ovf_c = push && full;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/dtc_pe_feeder.sv
// Packs serial FP32 (a,b) pairs into PE vectors, tracks the PE latency and collects results under credits.
// Define DTC_FEED_SPARSE_EN to accept +/-0 operand pairs without packing them.
module dtc_pe_feeder
  import dtc_pkg::*;
#(
  parameter int unsigned N_MUL      = 8,
  parameter int unsigned DW         = DW_FP32,
  parameter int unsigned PE_LAT     = PE_LAT_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic             clk,
  input logic             rst,
  dtc_pe_feeder_if.master bus
);

  localparam int unsigned VW  = DW * N_MUL;
  localparam int unsigned SW  = (N_MUL > 1) ? clog2(N_MUL) : 1;
  localparam int unsigned FCW = clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW  = clog2(PE_LAT + FIFO_DEPTH + 2);

  logic [SW-1:0]     cnt_q, cnt_d;
  logic [VW-1:0]     stg_a_q, stg_a_d, stg_b_q, stg_b_d;
  logic [VW-1:0]     pe_a_q, pe_a_d, pe_b_q, pe_b_d;
  logic              iss_q, iss_d, iss_last_q, iss_last_d;
  logic [PE_LAT-1:0] trk_v_q, trk_v_d, trk_l_q, trk_l_d;
  logic              err_ovf_q, err_ovf_d;

  logic [FCW-1:0]    fifo_count;
  logic              fifo_empty;
  logic              fifo_ovf_c;
  dtc_res_t          push_res_c, pop_res;
  logic [IW-1:0]     inflight_c;
  logic              s_ready_c, accept_c, skip_c, pack_c, complete_c;
  logic [VW-1:0]     merge_a_c, merge_b_c;

  // Credits: every issued group occupies a slot from issue until its result is popped.
  always_comb begin
    inflight_c = IW'(fifo_count) + IW'(iss_q);
    for (int unsigned i = 0; i < PE_LAT; i++) inflight_c = inflight_c + IW'(trk_v_q[i]);
  end

  assign s_ready_c = !rst && (inflight_c < IW'(FIFO_DEPTH));
  assign accept_c  = bus.s_valid && s_ready_c;

`ifdef DTC_FEED_SPARSE_EN
  assign skip_c = fp32_is_zero(DW_FP32'(bus.s_a)) || fp32_is_zero(DW_FP32'(bus.s_b));
`else
  assign skip_c = 1'b0;
`endif

  assign pack_c     = accept_c && !skip_c;
  assign complete_c = accept_c && (bus.s_last || (pack_c && (cnt_q == SW'(N_MUL - 1))));

  always_comb begin
    merge_a_c = stg_a_q;
    merge_b_c = stg_b_q;
    for (int unsigned i = 0; i < N_MUL; i++) begin
      if (pack_c && (cnt_q == SW'(i))) begin
        merge_a_c[DW*i +: DW] = bus.s_a;
        merge_b_c[DW*i +: DW] = bus.s_b;
      end
    end
  end

  // Packer, one-cycle issue register and latency tracker.
  always_comb begin
    cnt_d      = cnt_q;
    stg_a_d    = stg_a_q;
    stg_b_d    = stg_b_q;
    pe_a_d     = '0;
    pe_b_d     = '0;
    iss_d      = 1'b0;
    iss_last_d = 1'b0;
    if (complete_c) begin
      pe_a_d     = merge_a_c;
      pe_b_d     = merge_b_c;
      iss_d      = 1'b1;
      iss_last_d = bus.s_last;
      cnt_d      = '0;
      stg_a_d    = '0;
      stg_b_d    = '0;
    end else if (pack_c) begin
      stg_a_d = merge_a_c;
      stg_b_d = merge_b_c;
      cnt_d   = cnt_q + SW'(1);
    end
    // Stage k holds the issue made k+1 cycles ago; the top stage lines up with pe_out.
    trk_v_d   = (trk_v_q << 1) | PE_LAT'(iss_q);
    trk_l_d   = (trk_l_q << 1) | PE_LAT'(iss_last_q);
    err_ovf_d = err_ovf_q | fifo_ovf_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      stg_a_q    <= '0;
      stg_b_q    <= '0;
      pe_a_q     <= '0;
      pe_b_q     <= '0;
      iss_q      <= 1'b0;
      iss_last_q <= 1'b0;
      trk_v_q    <= '0;
      trk_l_q    <= '0;
      err_ovf_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      stg_a_q    <= stg_a_d;
      stg_b_q    <= stg_b_d;
      pe_a_q     <= pe_a_d;
      pe_b_q     <= pe_b_d;
      iss_q      <= iss_d;
      iss_last_q <= iss_last_d;
      trk_v_q    <= trk_v_d;
      trk_l_q    <= trk_l_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  assign push_res_c = '{last: trk_l_q[PE_LAT-1], data: DW_FP32'(bus.pe_out)};

  dtc_sync_fifo #(
    .W     ($bits(dtc_res_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (trk_v_q[PE_LAT-1]),
    .push_data (push_res_c),
    .pop       (bus.m_ready),
    .pop_data  (pop_res),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .ovf_c     (fifo_ovf_c)
  );

  assign bus.s_ready = s_ready_c;
  assign bus.pe_in_a = pe_a_q;
  assign bus.pe_in_b = pe_b_q;
  assign bus.m_valid = !fifo_empty;
  assign bus.m_data  = DW'(pop_res.data);
  assign bus.m_last  = pop_res.last;
  assign bus.err_ovf = err_ovf_q;

endmodule

// File: tb/tb_dtc_pe_feeder.sv
// Self-checking bench for dtc_pe_feeder: PE replaced by a lane-sum delay model, transaction-level scoreboard.
module tb_dtc_pe_feeder;

  localparam int unsigned N_MUL      = 8;
  localparam int unsigned DW         = 32;
  localparam int unsigned PE_LAT     = 12;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned VW         = DW * N_MUL;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dtc_pe_feeder_if #(.N_MUL(N_MUL), .DW(DW)) bus ();

  dtc_pe_feeder #(
    .N_MUL(N_MUL), .DW(DW), .PE_LAT(PE_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // PE stand-in: sum of all a and b lanes, delivered PE_LAT cycles after the vector is driven.
  logic [DW-1:0] hist [PE_LAT];
  always @(posedge clk) begin
    logic [DW-1:0] s;
    s = '0;
    for (int i = 0; i < N_MUL; i++) s = s + bus.pe_in_a[DW*i +: DW] + bus.pe_in_b[DW*i +: DW];
    for (int k = PE_LAT - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
    bus.pe_out <= hist[PE_LAT-1];
  end

  // Scoreboard state
  logic [DW-1:0] la[$], lb[$];
  logic [DW:0]   expq[$];
  int            outstanding;
  logic          issue_pend;
  logic [VW-1:0] exp_a, exp_b;
  int            n_pops;
  logic [DW:0]   last_pop;
  int            vectors;
  int            miscompares;

  typedef struct {
    int            n;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp_sum;
    int            exp_lat;
  } row_t;
  row_t rows [5];

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit op_zero(input logic [DW-1:0] x);
    return x[DW-2:0] == '0;
  endfunction

  // Group-level model: collect lanes, close on last or a full vector.
  task automatic model_accept(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last);
    bit skip;
    logic [DW-1:0] s;
    skip = 1'b0;
`ifdef DTC_FEED_SPARSE_EN
    skip = op_zero(a) || op_zero(b);
`endif
    if (!skip) begin
      la.push_back(a);
      lb.push_back(b);
    end
    if (last || la.size() == N_MUL) begin
      s = '0;
      exp_a = '0;
      exp_b = '0;
      foreach (la[i]) begin
        exp_a[DW*i +: DW] = la[i];
        exp_b[DW*i +: DW] = lb[i];
        s = s + la[i] + lb[i];
      end
      expq.push_back({last, s});
      la.delete();
      lb.delete();
      issue_pend = 1'b1;
      outstanding++;
    end
  endtask

  // One clock cycle: drive, resolve handshakes against the model, then check the post-edge state.
  task automatic tick(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic last, input logic mr,
                      output logic acc, output logic pop, output logic [DW:0] pd);
    bus.s_valid = v;
    bus.s_a     = a;
    bus.s_b     = b;
    bus.s_last  = last;
    bus.m_ready = mr;
    #1;
    acc = v && bus.s_ready;
    pop = bus.m_valid && mr;
    pd  = {bus.m_last, bus.m_data};
    if (pop) begin
      n_pops++;
      last_pop = pd;
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got %0h, no result outstanding", pd);
      end else begin
        chk("result_order", VW'(pd), VW'(expq.pop_front()));
        outstanding--;
      end
    end
    issue_pend = 1'b0;
    if (acc) model_accept(a, b, last);
    @(posedge clk);
    #1;
    chk("pe_in_a", bus.pe_in_a, issue_pend ? exp_a : '0);
    chk("pe_in_b", bus.pe_in_b, issue_pend ? exp_b : '0);
    chk("s_ready_credit", VW'(bus.s_ready), VW'(outstanding < FIFO_DEPTH));
  endtask

  function automatic logic mr_of(input int mode);
    if (mode == 2) return 1'($urandom_range(0, 1));
    return mode != 0;
  endfunction

  task automatic idle(input int n, input int mode);
    logic acc, pop;
    logic [DW:0] pd;
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, mr_of(mode), acc, pop, pd);
  endtask

  task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last, input int mode);
    logic acc, pop;
    logic [DW:0] pd;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      tick(1'b1, a, b, last, mr_of(mode), acc, pop, pd);
      n++;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: pair %0h/%0h not accepted within %0d cycles", a, b, n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 300) begin
      idle(1, 1);
      n++;
    end
    chk("drain_pending", VW'(expq.size()), '0);
    chk("drain_m_valid", VW'(bus.m_valid), '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_a     = '0;
    bus.s_b     = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_s_ready", VW'(bus.s_ready), '0);
    chk("rst_pe_in_a", bus.pe_in_a, '0);
    chk("rst_pe_in_b", bus.pe_in_b, '0);
    chk("rst_m_valid", VW'(bus.m_valid), '0);
    chk("rst_m_data", VW'(bus.m_data), '0);
    chk("rst_m_last", VW'(bus.m_last), '0);
    chk("rst_err_ovf", VW'(bus.err_ovf), '0);
    rst = 1'b0;
    la.delete();
    lb.delete();
    expq.delete();
    outstanding = 0;
    issue_pend  = 1'b0;
    #1;
    chk("post_rst_s_ready", VW'(bus.s_ready), VW'(1));
  endtask

  function automatic logic [DW-1:0] rnd_op();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return '0;
    if (r == 1) return 32'h8000_0000;
    return $urandom;
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc, pop;
    logic [DW:0]   pd;
    logic [VW-1:0] ea, eb;
    int lat, p0;
    bit got;

    vectors = 0;
    miscompares = 0;
    n_pops = 0;
    outstanding = 0;
    issue_pend = 1'b0;

    rows[0] = '{n: 8, a: 32'h3F80_0000, b: 32'h4000_0000, exp_sum: 32'hFC00_0000, exp_lat: PE_LAT + 1};
    rows[1] = '{n: 3, a: 32'h3F80_0000, b: 32'h4000_0000, exp_sum: 32'h7E80_0000, exp_lat: PE_LAT + 1};
    rows[2] = '{n: 1, a: 32'h0000_0001, b: 32'h0000_0002, exp_sum: 32'h0000_0003, exp_lat: PE_LAT + 1};
    rows[3] = '{n: 5, a: 32'h0000_0010, b: 32'h0000_0001, exp_sum: 32'h0000_0055, exp_lat: PE_LAT + 1};
    rows[4] = '{n: 8, a: 32'h0000_0100, b: 32'h0000_0001, exp_sum: 32'h0000_0808, exp_lat: PE_LAT + 1};

    do_reset();

    // Table: one group per row, lanes, result value and issue-to-m_valid latency.
    for (int r = 0; r < 5; r++) begin
      for (int p = 0; p < rows[r].n; p++) send_pair(rows[r].a, rows[r].b, p == rows[r].n - 1, 1);
      ea = '0;
      eb = '0;
      for (int i = 0; i < rows[r].n; i++) begin
        ea[DW*i +: DW] = rows[r].a;
        eb[DW*i +: DW] = rows[r].b;
      end
      chk("row_lanes_a", bus.pe_in_a, ea);
      chk("row_lanes_b", bus.pe_in_b, eb);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 40) begin
        tick(1'b0, '0, '0, 1'b0, 1'b1, acc, pop, pd);
        if (pop) got = 1'b1;
        else lat++;
      end
      chk("row_latency", VW'(lat), VW'(rows[r].exp_lat));
      chk("row_result", VW'(pd), VW'({1'b1, rows[r].exp_sum}));
      drain();
    end

    // Backpressure: FIFO_DEPTH full groups stall the stream, then one more after pops resume.
    p0 = n_pops;
    for (int p = 0; p < FIFO_DEPTH * N_MUL; p++)
      send_pair(32'h100 + p, 32'h200 + p, (p % N_MUL) == N_MUL - 1, 0);
    chk("bp_stall_ready", VW'(bus.s_ready), '0);
    idle(PE_LAT + 4, 0);
    chk("bp_held_valid", VW'(bus.m_valid), VW'(1));
    chk("bp_no_pops", VW'(n_pops - p0), '0);
    chk("bp_err_ovf", VW'(bus.err_ovf), '0);
    for (int p = 0; p < N_MUL; p++) send_pair(32'h900 + p, 32'hA00 + p, p == N_MUL - 1, 1);
    drain();
    chk("bp_result_count", VW'(n_pops - p0), VW'(FIFO_DEPTH + 1));
    chk("bp_err_ovf_end", VW'(bus.err_ovf), '0);

    // Pop and issue in the same cycle at one credit short of the limit.
    for (int g = 0; g < FIFO_DEPTH - 1; g++) send_pair(32'h40 + g, 32'h50 + g, 1'b1, 0);
    idle(PE_LAT + 3, 0);
    chk("pi_ready_before", VW'(bus.s_ready), VW'(1));
    tick(1'b1, 32'h11, 32'h22, 1'b1, 1'b1, acc, pop, pd);
    chk("pi_both_fire", VW'({acc, pop}), VW'(2'b11));
    chk("pi_ready_after", VW'(bus.s_ready), VW'(1));
    drain();

    // Reset with two groups in flight: their results must never appear.
    send_pair(32'h5, 32'h6, 1'b1, 1);
    send_pair(32'h7, 32'h8, 1'b1, 1);
    idle(1, 1);
    do_reset();
    p0 = n_pops;
    idle(PE_LAT + 4, 1);
    chk("rst_flight_pops", VW'(n_pops - p0), '0);
    chk("rst_flight_m_data", VW'(bus.m_data), '0);
    chk("rst_flight_m_last", VW'(bus.m_last), '0);
    send_pair(32'h3F80_0000, 32'h4000_0000, 1'b1, 1);
    drain();
    chk("rst_fresh_result", VW'(last_pop), VW'({1'b1, 32'h7F80_0000}));

`ifdef DTC_FEED_SPARSE_EN
    // Zero operands are dropped; a last-tagged zero pair still closes the group.
    p0 = n_pops;
    send_pair(32'h0000_0000, 32'h1234_5678, 1'b0, 1);
    send_pair(32'h3F80_0000, 32'h4000_0000, 1'b0, 1);
    send_pair(32'h4040_0000, 32'h8000_0000, 1'b1, 1);
    chk("sparse_lane_a", bus.pe_in_a, VW'(32'h3F80_0000));
    chk("sparse_lane_b", bus.pe_in_b, VW'(32'h4000_0000));
    drain();
    send_pair(32'h0000_0000, 32'h4000_0000, 1'b1, 1);
    chk("sparse_zero_vec", bus.pe_in_a, '0);
    drain();
    chk("sparse_pops", VW'(n_pops - p0), VW'(2));
    chk("sparse_last_only", VW'(last_pop), VW'({1'b1, 32'h0}));
`endif

    // Random traffic with gaps, random m_ready and occasional zero operands.
    for (int p = 0; p < 300; p++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 2);
      send_pair(rnd_op(), rnd_op(), $urandom_range(0, 3) == 0, 2);
    end
    send_pair(32'h1, 32'h1, 1'b1, 2);
    drain();
    chk("final_err_ovf", VW'(bus.err_ovf), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
